// File: rtl/controladora_pkg.sv
// Shared types and helpers for the multi-channel light controller.
// State encoding puts mode in bit 1 and drive in bit 0.
package controladora_pkg;

  typedef enum logic [1:0] {
    AUTO_OFF = 2'b00,
    AUTO_ON  = 2'b01,
    MAN_OFF  = 2'b10,
    MAN_ON   = 2'b11
  } estado_t;

  function automatic int largura_timer(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/canal_controladora.sv
// One light channel: input sync, press counter, mode FSM and timers.
// led/saida are the two bits of the state register itself.
module canal_controladora
  import controladora_pkg::*;
#(
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5300,
  parameter int AUTO_SHUTDOWN_T   = 30000,
  parameter int MANUAL_TIMEOUT_T  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  output logic led,
  output logic saida
);

  localparam int HW = $clog2(SWITCH_MODE_MIN_T + 1);
  localparam int TW = largura_timer(AUTO_SHUTDOWN_T, MANUAL_TIMEOUT_T);
  localparam logic [HW-1:0] HOLD_MAX = HW'(SWITCH_MODE_MIN_T);
  localparam logic [HW-1:0] HOLD_PRE = HW'(SWITCH_MODE_MIN_T - 1);
  localparam logic [HW-1:0] HOLD_MIN = HW'(DEBOUNCE_P);
  localparam logic [TW-1:0] T_AUTO   = TW'(AUTO_SHUTDOWN_T);
  localparam logic [TW-1:0] T_MAN    = TW'(MANUAL_TIMEOUT_T);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam bit MAN_TO = (MANUAL_TIMEOUT_T > 0);

  logic [1:0]    b_sync;
  logic [1:0]    ir_sync;
  logic          b;
  logic          ir;
  logic [HW-1:0] hold;
  logic          toggle;
  logic          short_press;
  estado_t       estado;
  estado_t       estado_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;

  assign b  = b_sync[1];
  assign ir = ir_sync[1];

  // Hold reaching the threshold this cycle flips the mode; a saturated
  // counter on release means the press was already consumed.
  assign toggle      = b && (hold == HOLD_PRE);
  assign short_press = !b && (hold >= HOLD_MIN) && (hold != HOLD_MAX);

  assign led   = estado[1];
  assign saida = estado[0];

  // Two-flop synchronizers on the raw pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_sync  <= '0;
      ir_sync <= '0;
    end else begin
      b_sync  <= {b_sync[0], push_button};
      ir_sync <= {ir_sync[0], infravermelho};
    end
  end

  // Saturating count of consecutive synchronized press cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (!b) begin
      hold <= '0;
    end else if (hold != HOLD_MAX) begin
      hold <= hold + 1'b1;
    end
  end

  // State and shared timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= AUTO_OFF;
      timer  <= '0;
    end else begin
      estado <= estado_n;
      timer  <= timer_n;
    end
  end

  // Next state: mode toggle first, then per-mode behaviour.
  always_comb begin
    estado_n = estado;
    timer_n  = timer;
    if (toggle) begin
      estado_n = estado[1] ? AUTO_OFF : MAN_OFF;
      timer_n  = '0;
    end else begin
      unique case (estado)
        AUTO_OFF: begin
          if (ir) begin
            estado_n = AUTO_ON;
            timer_n  = T_AUTO;
          end
        end
        AUTO_ON: begin
          if (ir) begin
            timer_n = T_AUTO;
          end else if (timer <= T_ONE) begin
            estado_n = AUTO_OFF;
            timer_n  = '0;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        MAN_OFF: begin
          if (short_press) begin
            estado_n = MAN_ON;
            timer_n  = T_MAN;
          end
        end
        MAN_ON: begin
          if (short_press || (MAN_TO && timer <= T_ONE)) begin
            estado_n = MAN_OFF;
            timer_n  = '0;
          end else if (MAN_TO) begin
            timer_n = timer - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/controladora_multi.sv
// N independent light channels plus a registered count of
// channels currently driving their load.
module controladora_multi
  import controladora_pkg::*;
#(
  parameter int N_CANAIS          = 4,
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5300,
  parameter int AUTO_SHUTDOWN_T   = 30000,
  parameter int MANUAL_TIMEOUT_T  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CANAIS-1:0]           push_button,
  input  logic [N_CANAIS-1:0]           infravermelho,
  output logic [N_CANAIS-1:0]           led,
  output logic [N_CANAIS-1:0]           saida,
  output logic [$clog2(N_CANAIS+1)-1:0] ativos
);

  localparam int AW = $clog2(N_CANAIS + 1);

  logic [AW-1:0] soma;

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    canal_controladora #(
      .DEBOUNCE_P       (DEBOUNCE_P),
      .SWITCH_MODE_MIN_T(SWITCH_MODE_MIN_T),
      .AUTO_SHUTDOWN_T  (AUTO_SHUTDOWN_T),
      .MANUAL_TIMEOUT_T (MANUAL_TIMEOUT_T)
    ) u_canal (
      .clk          (clk),
      .rst          (rst),
      .push_button  (push_button[i]),
      .infravermelho(infravermelho[i]),
      .led          (led[i]),
      .saida        (saida[i])
    );
  end

  // Popcount of the channel drives.
  always_comb begin
    soma = '0;
    for (int k = 0; k < N_CANAIS; k++) begin
      soma = soma + AW'(saida[k]);
    end
  end

  // Registered active-channel count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ativos <= '0;
    end else begin
      ativos <= soma;
    end
  end

endmodule

// File: tb/tb_controladora_multi.sv
// Scoreboard bench for controladora_multi with scaled timing parameters.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_controladora_multi;

  localparam int N    = 4;
  localparam int DEB  = 30;
  localparam int SW   = 530;
  localparam int AUTO = 3000;
  localparam int MT   = 100;
  localparam int AW   = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  push_button = '0;
  logic [N-1:0]  infravermelho = '0;
  logic [N-1:0]  led;
  logic [N-1:0]  saida;
  logic [AW-1:0] ativos;

  always #5 clk = ~clk;

  controladora_multi #(
    .N_CANAIS         (N),
    .DEBOUNCE_P       (DEB),
    .SWITCH_MODE_MIN_T(SW),
    .AUTO_SHUTDOWN_T  (AUTO),
    .MANUAL_TIMEOUT_T (MT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .infravermelho(infravermelho),
    .led          (led),
    .saida        (saida),
    .ativos       (ativos)
  );

  typedef struct packed {
    logic [N-1:0]  led;
    logic [N-1:0]  saida;
    logic [AW-1:0] ativos;
  } exp_t;

  exp_t  sb_q[$];
  string dn_q[$];
  int    da_q[$];
  int    de_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [N-1:0] m_d1, m_d2, m_i1, m_i2, m_mode, m_on;
  int m_len[N];
  int m_left[N];
  int m_cnt;

  task automatic model_clear();
    m_d1 = '0; m_d2 = '0; m_i1 = '0; m_i2 = '0;
    m_mode = '0; m_on = '0; m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      m_len[i] = 0;
      m_left[i] = 0;
    end
  endtask

  task automatic model_step();
    exp_t e;
    int prev;
    if (!rst) begin
      model_clear();
    end else begin
      prev = 0;
      for (int i = 0; i < N; i++) prev += int'(m_on[i]);
      for (int i = 0; i < N; i++) begin
        logic bb, irv, tog, shp;
        bb = m_d2[i]; irv = m_i2[i]; tog = 1'b0; shp = 1'b0;
        if (bb) begin
          if (m_len[i] < SW) begin
            m_len[i]++;
            tog = (m_len[i] == SW);
          end
        end else begin
          shp = (m_len[i] >= DEB) && (m_len[i] < SW);
          m_len[i] = 0;
        end
        if (tog) begin
          m_mode[i] = ~m_mode[i];
          m_on[i] = 1'b0;
          m_left[i] = 0;
        end else if (!m_mode[i]) begin
          if (irv) begin
            m_on[i] = 1'b1;
            m_left[i] = AUTO;
          end else if (m_on[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) m_on[i] = 1'b0;
          end
        end else if (m_on[i]) begin
          if (MT > 0) m_left[i]--;
          if (shp || (MT > 0 && m_left[i] == 0)) begin
            m_on[i] = 1'b0;
            m_left[i] = 0;
          end
        end else if (shp) begin
          m_on[i] = 1'b1;
          m_left[i] = MT;
        end
      end
      m_d2 = m_d1; m_d1 = push_button;
      m_i2 = m_i1; m_i1 = infravermelho;
      m_cnt = prev;
    end
    e.led = m_mode;
    e.saida = m_on;
    e.ativos = AW'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    dn_q.push_back(n);
    da_q.push_back(act);
    de_q.push_back(exp);
  endtask

  task automatic wait_bit(input int ch, input bit sel, input logic val,
                          input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (((sel ? saida[ch] : led[ch]) !== val) && n < budget);
  endtask

  task automatic reset_for(input int k);
    rst = 1'b0;
    model_clear();
    if (sb_q.size() > 0) sb_q[sb_q.size()-1] = '0;
    #1;
    chk("async_reset", int'({led, saida, ativos}), 0);
    repeat (k) cycle();
    rst = 1'b1;
  endtask

  // Monitor: compares every cycle's outputs and any directed checks.
  always @(negedge clk) begin
    exp_t e;
    int a, x;
    string nm;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({led, saida, ativos} !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL scoreboard @%0t: led=%b saida=%b ativos=%0d expected led=%b saida=%b ativos=%0d",
                   $time, led, saida, ativos, e.led, e.saida, e.ativos);
      end
    end
    while (dn_q.size() > 0) begin
      nm = dn_q.pop_front();
      a = da_q.pop_front();
      x = de_q.pop_front();
      checks++;
      if (a != x) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm, a, x);
      end
    end
  end

  int bcnt[N], bgap[N], icnt[N], igap[N];

  initial begin
    int n, low;
    model_clear();
    repeat (5) cycle();
    chk("reset_led", int'(led), 0);
    chk("reset_saida", int'(saida), 0);
    chk("reset_ativos", int'(ativos), 0);
    rst = 1'b1;
    repeat (5) cycle();

    // channel 0: long press enters manual mode
    push_button[0] = 1'b1;
    wait_bit(0, 0, 1'b1, SW + 50, n);
    chk("toggle_latency", n, SW + 2);
    chk("toggle_saida", int'(saida[0]), 0);
    repeat (540 - n) cycle();
    push_button[0] = 1'b0;
    repeat (10) cycle();
    chk("release_ignored", int'(led[0]), 1);

    // short press turns the load on
    push_button[0] = 1'b1;
    repeat (100) cycle();
    push_button[0] = 1'b0;
    wait_bit(0, 1, 1'b1, 50, n);
    chk("short_latency", n, 3);

    // glitch press while on is ignored
    repeat (5) cycle();
    push_button[0] = 1'b1;
    repeat (15) cycle();
    push_button[0] = 1'b0;
    repeat (8) cycle();
    chk("glitch_ignored", int'(saida[0]), 1);
    wait_bit(0, 1, 1'b0, MT + 50, n);
    chk("man_timeout_ch0", n, MT - 28);

    // back to automatic; short presses ignored there
    push_button[0] = 1'b1;
    wait_bit(0, 0, 1'b0, SW + 50, n);
    chk("toggle_back", n, SW + 2);
    repeat (10) cycle();
    push_button[0] = 1'b0;
    repeat (5) cycle();
    push_button[0] = 1'b1;
    repeat (100) cycle();
    push_button[0] = 1'b0;
    repeat (10) cycle();
    chk("auto_short_ignored", int'({led[0], saida[0]}), 0);

    // channel 1: automatic hold-off
    infravermelho[1] = 1'b1;
    wait_bit(1, 1, 1'b1, 20, n);
    chk("ir_latency", n, 3);
    repeat (50 - n) cycle();
    infravermelho[1] = 1'b0;
    wait_bit(1, 1, 1'b0, AUTO + 50, n);
    chk("holdoff", n, AUTO + 2);
    infravermelho[1] = 1'b1;
    repeat (50) cycle();
    infravermelho[1] = 1'b0;
    low = 0;
    for (int c = 0; c < 2010; c++) begin
      if (c == 2000) infravermelho[1] = 1'b1;
      cycle();
      if (!saida[1]) low++;
    end
    infravermelho[1] = 1'b0;
    wait_bit(1, 1, 1'b0, AUTO + 50, n);
    chk("holdoff_no_gap", low, 0);
    chk("holdoff_reload", n, AUTO + 2);

    // channel 3: manual timeout
    push_button[3] = 1'b1;
    wait_bit(3, 0, 1'b1, SW + 50, n);
    repeat (10) cycle();
    push_button[3] = 1'b0;
    repeat (5) cycle();
    push_button[3] = 1'b1;
    repeat (60) cycle();
    push_button[3] = 1'b0;
    wait_bit(3, 1, 1'b1, 20, n);
    wait_bit(3, 1, 1'b0, MT + 50, n);
    chk("man_timeout_ch3", n, MT);
    push_button[3] = 1'b1;
    wait_bit(3, 0, 1'b0, SW + 50, n);
    repeat (10) cycle();
    push_button[3] = 1'b0;
    repeat (5) cycle();

    // concurrency: all on, then mode toggle on channel 0 under IR
    infravermelho = '1;
    repeat (6) cycle();
    chk("all_on", int'(ativos), 4);
    push_button[0] = 1'b1;
    wait_bit(0, 0, 1'b1, SW + 50, n);
    chk("conc_saida0", int'(saida[0]), 0);
    chk("ativos_lag", int'(ativos), 4);
    cycle();
    chk("conc_ativos", int'(ativos), 3);
    repeat (10) cycle();
    push_button[0] = 1'b0;
    infravermelho = '0;
    repeat (AUTO + 10) cycle();
    chk("all_off", int'(ativos), 0);

    // reset during channel 2 hold-off
    infravermelho[2] = 1'b1;
    repeat (20) cycle();
    infravermelho[2] = 1'b0;
    repeat (500) cycle();
    chk("ch2_holding", int'(saida[2]), 1);
    reset_for(301);
    repeat (50) cycle();
    chk("post_reset", int'({led, saida}), 0);

    // random soak
    for (int i = 0; i < N; i++) begin
      bcnt[i] = 0; icnt[i] = 0;
      bgap[i] = $urandom_range(1, 600);
      igap[i] = $urandom_range(1, 4000);
    end
    for (int c = 0; c < 25000; c++) begin
      if (c % 2500 == 1250) reset_for($urandom_range(301, 1000));
      for (int i = 0; i < N; i++) begin
        if (bcnt[i] > 0) begin
          bcnt[i]--;
          if (bcnt[i] == 0) begin
            push_button[i] = 1'b0;
            bgap[i] = $urandom_range(1, 600);
          end
        end else if (bgap[i] > 0) begin
          bgap[i]--;
        end else begin
          push_button[i] = 1'b1;
          bcnt[i] = $urandom_range(30, 583);
        end
        if (icnt[i] > 0) begin
          icnt[i]--;
          if (icnt[i] == 0) begin
            infravermelho[i] = 1'b0;
            igap[i] = $urandom_range(1, 4000);
          end
        end else if (igap[i] > 0) begin
          igap[i]--;
        end else begin
          infravermelho[i] = 1'b1;
          icnt[i] = $urandom_range(1, 3000);
        end
      end
      cycle();
    end

    push_button = '0;
    infravermelho = '0;
    repeat (3) cycle();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
